// File: rtl/mpu_elemwise_sequencer.sv
// Element-wise ADD/SUB/RSUB sequencer for 5x5 int8 matrices: command, 25-pair load,
// single-cycle parallel execute on flattened registers, then 25-beat result drain.
module mpu_elemwise_sequencer #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DIM    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_a,
    input  logic [ELEM_W-1:0] in_b,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovf,
    output logic              err
);

    localparam int unsigned NELEM = DIM * DIM;
    localparam int unsigned BITS  = NELEM * ELEM_W;
    localparam int unsigned KW    = $clog2(NELEM);
    localparam int unsigned AW    = $clog2(BITS);
    localparam logic [KW-1:0] K_LAST = KW'(NELEM - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DRAIN} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_RSUB = 2'b10, OP_RSVD = 2'b11} op_t;

    state_t          r_state;
    state_t          w_state_nxt;
    op_t             r_op;
    logic [KW-1:0]   r_k;
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_b;
    logic [BITS-1:0] r_r;
    logic [BITS-1:0] w_res;
    logic [NELEM-1:0] w_elem_ovf;
    logic            r_ovf;
    logic            r_err;
    logic [AW-1:0]   w_base;
    logic            w_cmd_hs;
    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_k_last;

    assign cmd_ready = (r_state == S_IDLE);
    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_DRAIN);
    assign busy      = (r_state != S_IDLE);
    assign ovf       = r_ovf;
    assign err       = r_err;

    assign w_cmd_hs = cmd_valid & cmd_ready;
    assign w_in_hs  = in_valid & in_ready;
    assign w_out_hs = out_valid & out_ready;
    assign w_k_last = (r_k == K_LAST);
    assign w_base   = AW'(r_k) * AW'(ELEM_W);

    assign out_data = (r_state == S_DRAIN) ? r_r[w_base +: ELEM_W] : '0;
    assign out_last = (r_state == S_DRAIN) && w_k_last;

    // One extra bit per element holds the exact result; overflow when the top two bits differ.
    for (genvar g = 0; g < NELEM; g++) begin : g_elem
        logic signed [ELEM_W:0] w_ea;
        logic signed [ELEM_W:0] w_eb;
        logic signed [ELEM_W:0] w_full;

        assign w_ea = $signed({r_a[g*ELEM_W + ELEM_W - 1], r_a[g*ELEM_W +: ELEM_W]});
        assign w_eb = $signed({r_b[g*ELEM_W + ELEM_W - 1], r_b[g*ELEM_W +: ELEM_W]});

        always_comb begin
            w_full = w_ea + w_eb;
            case (r_op)
                OP_SUB:  w_full = w_ea - w_eb;
                OP_RSUB: w_full = w_eb - w_ea;
                default: w_full = w_ea + w_eb;
            endcase
        end

        assign w_res[g*ELEM_W +: ELEM_W] = w_full[ELEM_W-1:0];
        assign w_elem_ovf[g]             = w_full[ELEM_W] ^ w_full[ELEM_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_hs && (cmd_op != OP_RSVD)) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_in_hs && w_k_last)             w_state_nxt = S_EXEC;
            S_EXEC:                                       w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_hs && w_k_last)            w_state_nxt = S_IDLE;
            default:                                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op  <= OP_ADD;
            r_k   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        if (cmd_op == OP_RSVD) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op  <= op_t'(cmd_op);
                            r_ovf <= 1'b0;
                            r_k   <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_in_hs) begin
                        r_a[w_base +: ELEM_W] <= in_a;
                        r_b[w_base +: ELEM_W] <= in_b;
                        r_k <= w_k_last ? '0 : r_k + KW'(1);
                    end
                end
                S_EXEC: begin
                    r_r   <= w_res;
                    r_ovf <= |w_elem_ovf;
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        r_k <= w_k_last ? '0 : r_k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_elemwise_sequencer.sv
// Randomized bench for mpu_elemwise_sequencer: a transaction-level model predicts
// every output each cycle, plus literal checks on directed matrices.
module tb_mpu_elemwise_sequencer;

    localparam int unsigned N = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       out_ready = 1'b0;
    logic       cmd_ready, in_ready, out_valid, out_last, busy, ovf, err;
    logic [7:0] out_data;

    mpu_elemwise_sequencer #(.ELEM_W(8), .DIM(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: phase 0=idle 1=collecting pairs 2=compute 3=emitting results
    int         m_phase = 0;
    int         m_cnt = 0;
    logic [1:0] m_op = 2'd0;
    logic [7:0] m_a [N];
    logic [7:0] m_b [N];
    logic [7:0] m_res [N];
    logic       m_ovf = 1'b0;
    logic       m_err = 1'b0;
    int         m_t;
    logic       m_ov;

    logic [7:0] s_a [N];
    logic [7:0] s_b [N];
    logic [7:0] got [$];
    int         last_idx = -1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_ovf   <= 1'b0;
            m_err   <= 1'b0;
            for (int k = 0; k < N; k++) m_res[k] <= 8'd0;
        end else begin
            m_err <= 1'b0;
            case (m_phase)
                0: if (cmd_valid) begin
                    if (cmd_op == 2'd3) begin
                        m_err <= 1'b1;
                    end else begin
                        m_op    <= cmd_op;
                        m_ovf   <= 1'b0;
                        m_cnt   <= 0;
                        m_phase <= 1;
                    end
                end
                1: if (in_valid) begin
                    m_a[m_cnt] <= in_a;
                    m_b[m_cnt] <= in_b;
                    if (m_cnt == N - 1) begin
                        m_cnt   <= 0;
                        m_phase <= 2;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                2: begin
                    m_ov = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        case (m_op)
                            2'd1:    m_t = int'($signed(m_a[k])) - int'($signed(m_b[k]));
                            2'd2:    m_t = int'($signed(m_b[k])) - int'($signed(m_a[k]));
                            default: m_t = int'($signed(m_a[k])) + int'($signed(m_b[k]));
                        endcase
                        m_res[k] <= 8'(m_t);
                        if (m_t > 127 || m_t < -128) m_ov = 1'b1;
                    end
                    m_ovf   <= m_ov;
                    m_phase <= 3;
                end
                default: if (out_ready) begin
                    if (m_cnt == N - 1) begin
                        m_cnt   <= 0;
                        m_phase <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 8'(cmd_ready), 8'(m_phase == 0));
            chk("in_ready",  8'(in_ready),  8'(m_phase == 1));
            chk("out_valid", 8'(out_valid), 8'(m_phase == 3));
            chk("busy",      8'(busy),      8'(m_phase != 0));
            chk("out_last",  8'(out_last),  8'(m_phase == 3 && m_cnt == N - 1));
            chk("out_data",  out_data,      (m_phase == 3) ? m_res[m_cnt] : 8'd0);
            chk("ovf",       8'(ovf),       8'(m_ovf));
            chk("err",       8'(err),       8'(m_err));
            if (rst_n && out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last) last_idx = got.size() - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load(input int n, input bit gaps, input bit noise);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < 3 && gaps && $urandom_range(0, 2) == 0; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid  = 1'b1;
            in_a      = s_a[k];
            in_b      = s_b[k];
            cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input bit bp, input bit noise);
        int cyc;
        bit tog;
        cyc = 0;
        tog = 1'b1;
        while (m_phase != 0 && cyc < 300) begin
            out_ready = bp ? tog : 1'b1;
            tog       = ~tog;
            in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
        if (m_phase != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got phase %0d expected 0", m_phase);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input bit gaps, input bit bp, input bit noise);
        got.delete();
        last_idx = -1;
        send_cmd(op);
        load(N, gaps, noise);
        drain(bp, noise);
        chk("beat_count", 8'(got.size()), 8'd25);
        chk("last_index", 8'(last_idx), 8'd24);
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // SUB a=k, b=1
        for (int k = 0; k < N; k++) begin
            s_a[k] = 8'(k);
            s_b[k] = 8'd1;
        end
        run_op(2'd1, 1'b0, 1'b0, 1'b0);
        chk("sub_k0", got[0], 8'hFF);
        chk("sub_k10", got[10], 8'd9);
        chk("sub_k24", got[24], 8'd23);
        chk("sub_model_k0", m_res[0], 8'hFF);
        chk("sub_ovf", 8'(ovf), 8'd0);

        // ADD wrap at k=3
        for (int k = 0; k < N; k++) begin
            s_a[k] = 8'd0;
            s_b[k] = 8'd0;
        end
        s_a[3] = 8'd127;
        s_b[3] = 8'd1;
        run_op(2'd0, 1'b0, 1'b0, 1'b0);
        chk("wrap_k3", got[3], 8'h80);
        chk("wrap_k2", got[2], 8'h00);
        chk("wrap_ovf", 8'(ovf), 8'd1);

        // Reserved opcode: err pulse, ovf untouched
        send_cmd(2'd3);
        chk("rsvd_err", 8'(err), 8'd1);
        chk("rsvd_busy", 8'(busy), 8'd0);
        chk("rsvd_ovf_kept", 8'(ovf), 8'd1);
        tick();
        chk("rsvd_err_pulse", 8'(err), 8'd0);

        // RSUB of -128 against 0 wraps everywhere
        for (int k = 0; k < N; k++) begin
            s_a[k] = 8'h80;
            s_b[k] = 8'd0;
        end
        run_op(2'd2, 1'b0, 1'b0, 1'b0);
        chk("rsub_k0", got[0], 8'h80);
        chk("rsub_k24", got[24], 8'h80);
        chk("rsub_ovf", 8'(ovf), 8'd1);
        for (int k = 0; k < N; k++) s_a[k] = 8'd0;
        run_op(2'd0, 1'b0, 1'b0, 1'b0);
        chk("zero_k12", got[12], 8'd0);
        chk("zero_ovf", 8'(ovf), 8'd0);

        // Reset while loading pair 7
        for (int k = 0; k < N; k++) begin
            s_a[k] = 8'($urandom);
            s_b[k] = 8'($urandom);
        end
        send_cmd(2'd0);
        load(7, 1'b0, 1'b0);
        chk("midload_busy", 8'(busy), 8'd1);
        rst_n = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_data", out_data, 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        rst_n = 1'b1;
        tick();

        // Backpressure, input gaps and protocol noise, then random traffic
        run_op(2'($urandom_range(0, 2)), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                s_a[k] = 8'($urandom);
                s_b[k] = 8'($urandom);
            end
            run_op(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
